// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared constants and types for the register file
// Default geometry and the hardwired-zero register index.
package register_file_pkg;

   localparam int DEFAULT_N    = 32;
   localparam int DEFAULT_ADDR = 5;
   localparam int ZERO_REG     = 0;

   typedef logic [DEFAULT_N-1:0] defaultWordT;

endpackage

// File: rtl/register_file_rf_read_port.sv
// rtl/register_file_rf_read_port.sv - one combinational read port of the register file
// REGISTER_FILE_WRITE_BYPASS_EN adds write-through forwarding from the write port.
module rf_read_port
   import register_file_pkg::*;
#(
   parameter int N    = DEFAULT_N,
   parameter int ADDR = DEFAULT_ADDR
)(
   input  logic [N-1:0]    regBank [2**ADDR],
   input  logic [ADDR-1:0] readAddr,
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
   input  logic            reset,
   input  logic            writeEn,
   input  logic [ADDR-1:0] writeAddr,
   input  logic [N-1:0]    writeData,
`endif
   output logic [N-1:0]    readData
);

   always_comb begin
      readData = regBank[readAddr];
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
      if (!reset && writeEn && (writeAddr == readAddr)) begin
         readData = writeData;
      end
`endif
      // Applied last so a forwarded write to register 0 can never leak out.
      if (readAddr == ADDR'(ZERO_REG)) begin
         readData = '0;
      end
   end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 2R1W general-purpose register file with hardwired-zero register 0
// Optional write-through forwarding on both read ports under REGISTER_FILE_WRITE_BYPASS_EN.
module register_file
   import register_file_pkg::*;
#(
   parameter int N    = DEFAULT_N,
   parameter int ADDR = DEFAULT_ADDR
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            Reg_Write_i,
   input  logic [ADDR-1:0] Write_Register_i,
   input  logic [N-1:0]    Write_Data_i,
   input  logic [ADDR-1:0] Read_Register_1_i,
   input  logic [ADDR-1:0] Read_Register_2_i,
   output logic [N-1:0]    Read_Data_1_o,
   output logic [N-1:0]    Read_Data_2_o
);

   localparam int DEPTH = 2**ADDR;

   typedef logic [N-1:0] wordT;

   wordT regBank [DEPTH];

   // Register 0 is never written, so after the first reset it holds zero forever.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regBank[i] <= '0;
         end
      end else if (Reg_Write_i && (Write_Register_i != ADDR'(ZERO_REG))) begin
         regBank[Write_Register_i] <= Write_Data_i;
      end
   end

   rf_read_port #(.N(N), .ADDR(ADDR)) readPort1 (
      .regBank   (regBank),
      .readAddr  (Read_Register_1_i),
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
      .reset     (reset),
      .writeEn   (Reg_Write_i),
      .writeAddr (Write_Register_i),
      .writeData (Write_Data_i),
`endif
      .readData  (Read_Data_1_o)
   );

   rf_read_port #(.N(N), .ADDR(ADDR)) readPort2 (
      .regBank   (regBank),
      .readAddr  (Read_Register_2_i),
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
      .reset     (reset),
      .writeEn   (Reg_Write_i),
      .writeAddr (Write_Register_i),
      .writeData (Write_Data_i),
`endif
      .readData  (Read_Data_2_o)
   );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file
// Reference model plus directed literal checks; honours REGISTER_FILE_WRITE_BYPASS_EN.
module tb_register_file;

   logic        clk = 1'b0;
   logic        reset;
   logic        Reg_Write_i;
   logic [4:0]  Write_Register_i;
   logic [31:0] Write_Data_i;
   logic [4:0]  Read_Register_1_i;
   logic [4:0]  Read_Register_2_i;
   logic [31:0] Read_Data_1_o;
   logic [31:0] Read_Data_2_o;

   int errors = 0;
   int checks = 0;

   logic [31:0] model [32];
   logic [31:0] sweepVals [32];
   bit          modelValid = 1'b0;

   register_file #(.N(32), .ADDR(5)) dut (
      .clk               (clk),
      .reset             (reset),
      .Reg_Write_i       (Reg_Write_i),
      .Write_Register_i  (Write_Register_i),
      .Write_Data_i      (Write_Data_i),
      .Read_Register_1_i (Read_Register_1_i),
      .Read_Register_2_i (Read_Register_2_i),
      .Read_Data_1_o     (Read_Data_1_o),
      .Read_Data_2_o     (Read_Data_2_o)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] expRead(input logic [4:0] addr);
      if (addr == 5'd0) return 32'h0;
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
      if (Reg_Write_i && !reset && (Write_Register_i == addr)) return Write_Data_i;
`endif
      return model[addr];
   endfunction

   // Advance one rising edge and apply the architectural write/reset rules to the model.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
         modelValid = 1'b1;
      end else if (Reg_Write_i && Write_Register_i != 5'd0) begin
         model[Write_Register_i] = Write_Data_i;
      end
      #1;
   endtask

   task automatic readCheck(input string tag, input int a1, input int a2,
                            input logic [31:0] e1, input logic [31:0] e2);
      Read_Register_1_i = 5'(a1);
      Read_Register_2_i = 5'(a2);
      #1;
      checkVal($sformatf("%s_p1[%0d]", tag, a1), Read_Data_1_o, e1);
      checkVal($sformatf("%s_p2[%0d]", tag, a2), Read_Data_2_o, e2);
   endtask

   always @(negedge clk) begin
      if (modelValid) begin
         checkVal("model_p1", Read_Data_1_o, expRead(Read_Register_1_i));
         checkVal("model_p2", Read_Data_2_o, expRead(Read_Register_2_i));
      end
   end

   initial begin
      reset = 1'b1;
      Reg_Write_i = 1'b0;
      Write_Register_i = '0;
      Write_Data_i = '0;
      Read_Register_1_i = '0;
      Read_Register_2_i = '0;

      tick();
      reset = 1'b0;
      readCheck("post_reset", 0, 5, 32'h0, 32'h0);
      readCheck("post_reset", 31, 17, 32'h0, 32'h0);

      // Write sweep, including a nonzero write to register 0.
      Reg_Write_i = 1'b1;
      for (int i = 0; i < 32; i++) begin
         sweepVals[i] = $urandom | 32'h1;
         Write_Register_i = 5'(i);
         Write_Data_i = sweepVals[i];
         tick();
      end
      Reg_Write_i = 1'b0;
      for (int i = 0; i < 32; i++) begin
         readCheck("sweep", i, 31 - i,
                   (i == 0) ? 32'h0 : sweepVals[i],
                   (i == 31) ? 32'h0 : sweepVals[31 - i]);
         tick();
      end

      // Address-only change with no clock edge.
      readCheck("async", 5, 6, sweepVals[5], sweepVals[6]);

      // Reset held between edges must not clear; the edge must.
      Reg_Write_i = 1'b1;
      Write_Register_i = 5'd7;
      Write_Data_i = 32'hDEADBEEF;
      tick();
      Reg_Write_i = 1'b0;
      readCheck("pre_reset", 7, 7, 32'hDEADBEEF, 32'hDEADBEEF);
      reset = 1'b1;
      readCheck("reset_no_edge", 7, 5, 32'hDEADBEEF, sweepVals[5]);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         readCheck("after_reset", i, 31 - i, 32'h0, 32'h0);
      end

      // Write enable low: nothing may change.
      Reg_Write_i = 1'b0;
      Write_Data_i = 32'hA5A5A5A5;
      for (int i = 0; i < 32; i++) begin
         Write_Register_i = 5'(i);
         tick();
      end
      for (int i = 0; i < 32; i++) begin
         readCheck("we_off", i, 31 - i, 32'h0, 32'h0);
      end

      // Reset wins over a simultaneous write.
      Reg_Write_i = 1'b1;
      Write_Register_i = 5'd3;
      Write_Data_i = 32'h00000077;
      tick();
      Reg_Write_i = 1'b0;
      readCheck("pre_collide", 3, 3, 32'h77, 32'h77);
      reset = 1'b1;
      Reg_Write_i = 1'b1;
      Write_Data_i = 32'h12345678;
      tick();
      reset = 1'b0;
      Reg_Write_i = 1'b0;
      readCheck("collide", 3, 3, 32'h0, 32'h0);

      // Same-address read during a write.
      Reg_Write_i = 1'b1;
      Write_Register_i = 5'd9;
      Write_Data_i = 32'h11;
      tick();
      Write_Data_i = 32'h55;
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
      readCheck("rw_same_before", 9, 8, 32'h55, 32'h0);
`else
      readCheck("rw_same_before", 9, 8, 32'h11, 32'h0);
`endif
      tick();
      Reg_Write_i = 1'b0;
      readCheck("rw_same_after", 9, 9, 32'h55, 32'h55);

      // Register 0 stays zero even while a nonzero write to it is pending.
      Reg_Write_i = 1'b1;
      Write_Register_i = 5'd0;
      Write_Data_i = 32'hFFFFFFFF;
      readCheck("zero_pending", 0, 9, 32'h0, 32'h55);
      tick();
      Reg_Write_i = 1'b0;
      readCheck("zero_after", 0, 0, 32'h0, 32'h0);

      // Data wiggles between edges with enable low must not leak into storage.
      Write_Register_i = 5'd12;
      Write_Data_i = 32'hCAFEF00D;
      tick();
      readCheck("no_we_data", 12, 9, 32'h0, 32'h55);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
